// File: rtl/vga_text_pkg.sv
// Shared definitions for the text-mode character writer: control codes,
// printable range and the writer's state type.
package vga_text_pkg;

    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_BLANK = 8'h20;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        ST_CLEAR_ALL  = 2'd0,
        ST_CLEAR_LINE = 2'd1,
        ST_IDLE       = 2'd2
    } vga_text_state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= PRINT_LO) && (b <= PRINT_HI);
    endfunction

endpackage

// File: rtl/vga_text_writer.sv
// Turns a byte stream into character-memory writes over a COLS x ROWS grid,
// handling CR, LF, BS and FF plus multi-cycle line and screen clears.
module vga_text_writer
    import vga_text_pkg::*;
#(
    parameter int         COLS   = 16,
    parameter int         ROWS   = 4,
    parameter int         ADDR_W = 6,
    parameter logic [7:0] BLANK  = CH_BLANK
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        char_in,
    input  logic              char_valid,
    output logic              char_ready,
    output logic [ADDR_W-1:0] addr_write,
    output logic [7:0]        char_write,
    output logic              write_enable,
    output logic [ADDR_W-1:0] cursor,
    output logic              busy
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [COL_W-1:0]  LAST_COL      = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW      = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_LINE_CNT = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL_CNT = ADDR_W'(COLS * ROWS - 1);

    vga_text_state_e   state;
    logic [ROW_W-1:0]  row;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] clr_cnt;

    logic [ROW_W-1:0]  next_row;
    logic [ADDR_W-1:0] next_base;
    logic              accept;

    // Handshake: a byte transfers on a rising edge where char_valid && char_ready.
    // char_ready is a pure decode of the state register, so the source may
    // hold char_valid high with any data while the writer is clearing.
    assign char_ready = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign accept     = char_valid && char_ready;

    always_comb begin
        next_row  = (row == LAST_ROW) ? '0 : row + 1'b1;
        next_base = ADDR_W'(next_row) * ADDR_W'(COLS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_CLEAR_ALL;
            clr_cnt      <= '0;
            row          <= '0;
            col          <= '0;
            cursor       <= '0;
            write_enable <= 1'b0;
            addr_write   <= '0;
            char_write   <= '0;
        end else begin
            write_enable <= 1'b0;
            case (state)
                ST_CLEAR_ALL: begin
                    write_enable <= 1'b1;
                    addr_write   <= clr_cnt;
                    char_write   <= BLANK;
                    if (clr_cnt == LAST_CELL_CNT) begin
                        clr_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end

                // The cursor sits at column 0 of the row being cleared.
                ST_CLEAR_LINE: begin
                    write_enable <= 1'b1;
                    addr_write   <= cursor + clr_cnt;
                    char_write   <= BLANK;
                    if (clr_cnt == LAST_LINE_CNT) begin
                        clr_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (accept) begin
                        if (is_printable(char_in)) begin
                            write_enable <= 1'b1;
                            addr_write   <= cursor;
                            char_write   <= char_in;
                            if (col != LAST_COL) begin
                                col    <= col + 1'b1;
                                cursor <= cursor + 1'b1;
                            end else begin
                                col     <= '0;
                                row     <= next_row;
                                cursor  <= next_base;
                                clr_cnt <= '0;
                                state   <= ST_CLEAR_LINE;
                            end
                        end else begin
                            case (char_in)
                                CH_LF: begin
                                    col     <= '0;
                                    row     <= next_row;
                                    cursor  <= next_base;
                                    clr_cnt <= '0;
                                    state   <= ST_CLEAR_LINE;
                                end
                                CH_CR: begin
                                    col    <= '0;
                                    cursor <= cursor - ADDR_W'(col);
                                end
                                // Backspace never wraps to the previous row.
                                CH_BS: begin
                                    if (col != '0) begin
                                        col          <= col - 1'b1;
                                        cursor       <= cursor - 1'b1;
                                        write_enable <= 1'b1;
                                        addr_write   <= cursor - 1'b1;
                                        char_write   <= BLANK;
                                    end
                                end
                                CH_FF: begin
                                    row     <= '0;
                                    col     <= '0;
                                    cursor  <= '0;
                                    clr_cnt <= '0;
                                    state   <= ST_CLEAR_ALL;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                default: begin
                    clr_cnt <= '0;
                    state   <= ST_CLEAR_ALL;
                end
            endcase
        end
    end

endmodule
